// File: rtl/board_io_pkg.sv
// Shared definitions for the board I/O controller: register offsets (word index
// within the 32-byte window), CTRL bit positions and the CTRL register layout.
package board_io_pkg;

  localparam logic [2:0] REG_LED  = 3'd0;
  localparam logic [2:0] REG_SW   = 3'd1;
  localparam logic [2:0] REG_KEY  = 3'd2;
  localparam logic [2:0] REG_EVT  = 3'd3;
  localparam logic [2:0] REG_CTRL = 3'd4;
  localparam logic [2:0] REG_DIM  = 3'd5;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_STEP   = 1;

  typedef struct packed {
    logic step_mode;
    logic irq_en;
  } ctrl_t;

endpackage

// File: rtl/board_io_debounce.sv
// Two-flop synchroniser followed by a per-bit debouncer: a bit's stable value
// flips only after the synchronised input has differed from it for CYCLES cycles.
module debounce
  import board_io_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               CYCLES  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable,
  output logic [WIDTH-1:0] o_next
);

  localparam int               CNT_W    = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // The count tracks how long the input has disagreed; agreement restarts it.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q  <= RST_VAL;
      sync2_q  <= RST_VAL;
      stable_q <= RST_VAL;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= i_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign o_stable = stable_q;
  assign o_next   = stable_d;

endmodule

// File: rtl/board_io.sv
// board_io: memory-mapped LEDs, debounced switches/keys, sticky key events with IRQ
// and a run/single-step CPU clock enable. Define BOARD_IO_LED_PWM_EN for LED dimming.
module board_io
  import board_io_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'(32'hFFFF_0000),
  parameter int                    LED_COUNT       = 8,
  parameter int                    SW_COUNT        = 4,
  parameter int                    KEY_COUNT       = 2,
  parameter int                    STEP_KEY        = 0,
  parameter int                    DEBOUNCE_CYCLES = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_we,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_sel,
  input  logic [SW_COUNT-1:0]   i_sw,
  input  logic [KEY_COUNT-1:0]  i_key,
  output logic [LED_COUNT-1:0]  o_led,
  output logic                  o_irq,
  output logic                  o_cpu_ce
);

  logic                  sel;
  logic [2:0]            offset;
  logic                  wr_en;
  logic                  unused_bits;

  logic [SW_COUNT-1:0]   sw_level;
  logic [SW_COUNT-1:0]   sw_next_unused;
  logic [KEY_COUNT-1:0]  key_raw_stable;
  logic [KEY_COUNT-1:0]  key_raw_next;
  logic [KEY_COUNT-1:0]  key_level;
  logic [KEY_COUNT-1:0]  key_rise;

  logic [LED_COUNT-1:0]  led_q, led_d;
  logic [KEY_COUNT-1:0]  evt_q, evt_d, evt_clr;
  ctrl_t                 ctrl_q, ctrl_d;
  logic                  irq_q, irq_d;
  logic                  cpu_ce_q, cpu_ce_d;
  logic [DATA_WIDTH-1:0] rdata;

  assign sel         = (i_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
  assign offset      = i_addr[4:2];
  assign wr_en       = i_we & sel;
  assign unused_bits = ^{i_addr[1:0], i_wdata};

  debounce #(
    .WIDTH  (SW_COUNT),
    .CYCLES (DEBOUNCE_CYCLES),
    .RST_VAL('0)
  ) u_sw_debounce (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_raw   (i_sw),
    .o_stable(sw_level),
    .o_next  (sw_next_unused)
  );

  // Keys are active-low, so the debouncer idles at all-ones (released).
  debounce #(
    .WIDTH  (KEY_COUNT),
    .CYCLES (DEBOUNCE_CYCLES),
    .RST_VAL({KEY_COUNT{1'b1}})
  ) u_key_debounce (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_raw   (i_key),
    .o_stable(key_raw_stable),
    .o_next  (key_raw_next)
  );

  assign key_level = ~key_raw_stable;
  assign key_rise  = key_raw_stable & ~key_raw_next;

  // A press landing on the same edge as its W1C wins, so the event is never lost.
  always_comb begin
    led_d   = led_q;
    ctrl_d  = ctrl_q;
    evt_clr = '0;
    if (wr_en) begin
      case (offset)
        REG_LED: led_d = i_wdata[LED_COUNT-1:0];
        REG_CTRL: begin
          ctrl_d.irq_en    = i_wdata[CTRL_IRQ_EN];
          ctrl_d.step_mode = i_wdata[CTRL_STEP];
        end
        REG_EVT: evt_clr = i_wdata[KEY_COUNT-1:0];
        default: ;
      endcase
    end
    evt_d    = (evt_q & ~evt_clr) | key_rise;
    irq_d    = ctrl_q.irq_en & (|evt_q);
    cpu_ce_d = ctrl_q.step_mode ? key_rise[STEP_KEY] : 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      led_q    <= '0;
      ctrl_q   <= '0;
      evt_q    <= '0;
      irq_q    <= 1'b0;
      cpu_ce_q <= 1'b1;
    end else begin
      led_q    <= led_d;
      ctrl_q   <= ctrl_d;
      evt_q    <= evt_d;
      irq_q    <= irq_d;
      cpu_ce_q <= cpu_ce_d;
    end
  end

`ifdef BOARD_IO_LED_PWM_EN
  logic [7:0]           dim_q, dim_d;
  logic [7:0]           pwm_cnt_q, pwm_cnt_d;
  logic [LED_COUNT-1:0] led_out_q, led_out_d;

  // LEDs are on while the free-running counter is below the duty value.
  always_comb begin
    dim_d = dim_q;
    if (wr_en && offset == REG_DIM) begin
      dim_d = i_wdata[7:0];
    end
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    led_out_d = led_q & {LED_COUNT{pwm_cnt_q < dim_q}};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dim_q     <= 8'hFF;
      pwm_cnt_q <= 8'd0;
      led_out_q <= '0;
    end else begin
      dim_q     <= dim_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_out_q <= led_out_d;
    end
  end

  assign o_led = led_out_q;
`else
  assign o_led = led_q;
`endif

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset)
        REG_LED:  rdata = DATA_WIDTH'(led_q);
        REG_SW:   rdata = DATA_WIDTH'(sw_level);
        REG_KEY:  rdata = DATA_WIDTH'(key_level);
        REG_EVT:  rdata = DATA_WIDTH'(evt_q);
        REG_CTRL: rdata = DATA_WIDTH'(ctrl_q);
`ifdef BOARD_IO_LED_PWM_EN
        REG_DIM:  rdata = DATA_WIDTH'(dim_q);
`else
        REG_DIM:  rdata = '0;
`endif
        default:  rdata = '0;
      endcase
    end
  end

  assign o_rdata  = rdata;
  assign o_sel    = sel;
  assign o_irq    = irq_q;
  assign o_cpu_ce = cpu_ce_q;

endmodule

// File: tb/tb_board_io.sv
// Self-checking bench for board_io with DEBOUNCE_CYCLES=4: expected bus reads and
// output levels are queued as stimulus is applied and compared at the next negedge.
module tb_board_io;

  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam logic [31:0] A_LED  = BASE + 32'h00;
  localparam logic [31:0] A_SW   = BASE + 32'h04;
  localparam logic [31:0] A_KEY  = BASE + 32'h08;
  localparam logic [31:0] A_EVT  = BASE + 32'h0C;
  localparam logic [31:0] A_CTRL = BASE + 32'h10;
  localparam logic [31:0] A_DIM  = BASE + 32'h14;

  localparam int K_RDATA = 0;
  localparam int K_SEL   = 1;
  localparam int K_LED   = 2;
  localparam int K_IRQ   = 3;
  localparam int K_CE    = 4;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] value;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        sel;
  logic [3:0]  sw;
  logic [1:0]  key;
  logic [7:0]  led;
  logic        irq;
  logic        cpuCe;

  exp_t expQ[$];
  int   checkCount = 0;
  int   errorCount = 0;

  board_io #(
    .BASE_ADDR      (32'hFFFF_0000),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_addr  (addr),
    .i_wdata (wdata),
    .i_we    (we),
    .o_rdata (rdata),
    .o_sel   (sel),
    .i_sw    (sw),
    .i_key   (key),
    .o_led   (led),
    .o_irq   (irq),
    .o_cpu_ce(cpuCe)
  );

  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input int kind, input logic [31:0] value);
    exp_t ent;
    ent.tag   = tag;
    ent.kind  = kind;
    ent.value = value;
    expQ.push_back(ent);
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_RDATA: return rdata;
      K_SEL:   return {31'b0, sel};
      K_LED:   return 32'(led);
      K_IRQ:   return {31'b0, irq};
      K_CE:    return {31'b0, cpuCe};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Compare everything queued for this cycle, then move just past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    while (expQ.size() > 0) begin
      exp_t ent;
      ent = expQ.pop_front();
      checkOutput(ent.tag, observe(ent.kind), ent.value);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w);
    addr  = a;
    wdata = d;
    we    = w;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(a, d, 1'b1);
    cycle();
    applyStimulus(a, 32'h0, 1'b0);
  endtask

  task automatic expectRead(input string tag, input logic [31:0] a, input logic [31:0] v);
    applyStimulus(a, 32'h0, 1'b0);
    pushExpect(tag, K_RDATA, v);
    pushExpect({tag, "_sel"}, K_SEL, 32'h1);
    cycle();
  endtask

  initial begin
    int onCount;

    rstN = 1'b0;
    sw   = 4'b0000;
    key  = 2'b11;
    applyStimulus(A_LED, 32'h0, 1'b0);
    @(posedge clk);
    #1;

    // Reset held while inputs toggle.
    for (int i = 0; i < 6; i++) begin
      sw  = 4'($urandom);
      key = 2'($urandom);
      if (i == 5) begin
        pushExpect("rst_led", K_LED, 32'h0);
        pushExpect("rst_irq", K_IRQ, 32'h0);
        pushExpect("rst_ce", K_CE, 32'h1);
      end
      cycle();
    end
    expectRead("rst_key", A_KEY, 32'h0);
    expectRead("rst_evt", A_EVT, 32'h0);
    sw  = 4'b0000;
    key = 2'b11;
    repeat (3) cycle();
    rstN = 1'b1;
    repeat (10) cycle();
    expectRead("post_rst_sw", A_SW, 32'h0);
    expectRead("post_rst_key", A_KEY, 32'h0);
    pushExpect("post_rst_irq", K_IRQ, 32'h0);
    pushExpect("post_rst_ce", K_CE, 32'h1);
    expectRead("post_rst_evt", A_EVT, 32'h0);

    // LED register, window decode and ignored writes.
    busWrite(A_LED, 32'h0000_00A5);
`ifndef BOARD_IO_LED_PWM_EN
    pushExpect("led_out", K_LED, 32'hA5);
`endif
    expectRead("led_rd", A_LED, 32'hA5);
    expectRead("led_rd_lowbits", A_LED + 32'h3, 32'hA5);
    expectRead("rd_0x18", BASE + 32'h18, 32'h0);
    busWrite(BASE + 32'h18, 32'hFFFF_FFFF);
    busWrite(A_SW, 32'hF);
    expectRead("sw_ro", A_SW, 32'h0);
    busWrite(32'hFFFE_0000, 32'h3C);
    expectRead("led_outside_wr", A_LED, 32'hA5);
    applyStimulus(32'hFFFE_0000, 32'h0, 1'b0);
    pushExpect("outside_sel", K_SEL, 32'h0);
    pushExpect("outside_rdata", K_RDATA, 32'h0);
    cycle();
`ifndef BOARD_IO_LED_PWM_EN
    busWrite(A_DIM, 32'h40);
    expectRead("dim_absent", A_DIM, 32'h0);
`endif

    // Switch glitch shorter than the debounce window, then a settled change.
    applyStimulus(A_SW, 32'h0, 1'b0);
    sw = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      pushExpect("sw_glitch_hi", K_RDATA, 32'h0);
      cycle();
    end
    sw = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      pushExpect("sw_glitch_lo", K_RDATA, 32'h0);
      cycle();
    end
    sw = 4'b1010;
    for (int i = 0; i <= 6; i++) begin
      pushExpect($sformatf("sw_settle_%0d", i), K_RDATA, (i >= 6) ? 32'hA : 32'h0);
      cycle();
    end

    // Key1 press raises EVT[1] with KEY[1]; IRQ follows a cycle later.
    busWrite(A_CTRL, 32'h1);
    expectRead("ctrl_rd", A_CTRL, 32'h1);
    applyStimulus(A_EVT, 32'h0, 1'b0);
    key = 2'b01;
    for (int i = 0; i <= 7; i++) begin
      pushExpect($sformatf("evt_press_%0d", i), K_RDATA, (i >= 6) ? 32'h2 : 32'h0);
      pushExpect($sformatf("irq_press_%0d", i), K_IRQ, (i >= 7) ? 32'h1 : 32'h0);
      cycle();
    end
    expectRead("key_pressed", A_KEY, 32'h2);
    key = 2'b11;
    repeat (8) cycle();
    expectRead("evt_no_release_evt", A_EVT, 32'h2);
    expectRead("key_released", A_KEY, 32'h0);
    busWrite(A_EVT, 32'h2);
    pushExpect("irq_lag_after_w1c", K_IRQ, 32'h1);
    expectRead("evt_w1c", A_EVT, 32'h0);
    pushExpect("irq_cleared", K_IRQ, 32'h0);
    cycle();

    // W1C landing on the same edge as a new press keeps the bit.
    key = 2'b01;
    repeat (5) cycle();
    busWrite(A_EVT, 32'h2);
    expectRead("evt_w1c_collide", A_EVT, 32'h2);
    busWrite(A_EVT, 32'h1);
    expectRead("evt_w1c_other_bit", A_EVT, 32'h2);
    key = 2'b11;
    repeat (8) cycle();
    busWrite(A_EVT, 32'h2);
    expectRead("evt_cleared", A_EVT, 32'h0);

    // Step mode: one CE pulse per key0 press.
    busWrite(A_CTRL, 32'h2);
    pushExpect("ce_step_lag", K_CE, 32'h1);
    cycle();
    for (int p = 0; p < 3; p++) begin
      key = 2'b10;
      for (int i = 0; i < 8; i++) begin
        pushExpect($sformatf("ce_press%0d_%0d", p, i), K_CE, (i == 6) ? 32'h1 : 32'h0);
        cycle();
      end
      key = 2'b11;
      for (int i = 0; i < 8; i++) begin
        pushExpect($sformatf("ce_release%0d_%0d", p, i), K_CE, 32'h0);
        cycle();
      end
    end
    pushExpect("irq_disabled", K_IRQ, 32'h0);
    expectRead("evt_key0", A_EVT, 32'h1);
    applyStimulus(A_CTRL, 32'h0, 1'b1);
    pushExpect("ce_before_run", K_CE, 32'h0);
    cycle();
    applyStimulus(A_CTRL, 32'h0, 1'b0);
    pushExpect("ce_run_lag", K_CE, 32'h0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      pushExpect($sformatf("ce_run_%0d", i), K_CE, 32'h1);
      cycle();
    end
    busWrite(A_EVT, 32'h1);

`ifdef BOARD_IO_LED_PWM_EN
    // PWM duty 64/256, then fully off.
    busWrite(A_DIM, 32'h40);
    busWrite(A_LED, 32'hFF);
    expectRead("dim_rd", A_DIM, 32'h40);
    repeat (2) cycle();
    onCount = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led == 8'hFF) onCount++;
      else if (led != 8'h00) checkOutput("pwm_level", 32'(led), 32'hFF);
      @(posedge clk);
      #1;
    end
    checkOutput("pwm_on_count_64", onCount, 32'd64);
    busWrite(A_DIM, 32'h0);
    repeat (2) cycle();
    onCount = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led != 8'h00) onCount++;
      @(posedge clk);
      #1;
    end
    checkOutput("pwm_on_count_0", onCount, 32'd0);
`else
    onCount = 0;
    busWrite(A_LED, 32'h3C);
    pushExpect("led_direct", K_LED, 32'h3C);
    cycle();
`endif

    // Reset mid-debounce and during step mode.
    busWrite(A_CTRL, 32'h2);
    sw = 4'b0101;
    repeat (4) cycle();
    rstN = 1'b0;
    pushExpect("rst_step_ce", K_CE, 32'h1);
    cycle();
    cycle();
    rstN = 1'b1;
    applyStimulus(A_SW, 32'h0, 1'b0);
    for (int i = 0; i <= 6; i++) begin
      pushExpect($sformatf("sw_after_rst_%0d", i), K_RDATA, (i >= 6) ? 32'h5 : 32'h0);
      cycle();
    end
    pushExpect("ce_run_after_rst", K_CE, 32'h1);
    expectRead("ctrl_after_rst", A_CTRL, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
